// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core front end.
package core_pkg;
    localparam int WIDTH_DEFAULT = 16;
    localparam logic [15:0] RESET_VEC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/pcALU.sv
// Next-PC unit: increment, relative jump, or absolute jump-and-link with link value.
module pcALU #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] immediate,
    input  logic             jumpEN,
    input  logic [WIDTH-1:0] RTarget,
    input  logic             jalEN,
    output logic [WIDTH-1:0] pcOut,
    output logic [WIDTH-1:0] Rlink
);
    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] jmp;

    assign inc   = pc + WIDTH'(1);
    assign jmp   = pc + immediate;
    assign Rlink = inc;
    assign pcOut = jalEN ? RTarget : (jumpEN ? jmp : inc);
endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, issues one imem read at a time,
// buffers the word toward decode and applies execute-stage redirects.
module fetch_seq
    import core_pkg::*;
#(
    parameter int             WIDTH     = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             instr_ready,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_pc,
    input  logic             jump_en,
    input  logic [WIDTH-1:0] jump_imm,
    input  logic             jal_en,
    input  logic [WIDTH-1:0] jal_target,
    output logic             link_we,
    output logic [WIDTH-1:0] link_data
);
    fetch_state_t     state, state_nxt;
    logic [WIDTH-1:0] pc, pc_nxt;
    logic [WIDTH-1:0] pend_pc, pend_pc_nxt;
    logic             flush, flush_nxt;
    logic [WIDTH-1:0] instr_nxt, instr_pc_nxt;
    logic             instr_valid_nxt;
    logic             link_we_nxt;
    logic [WIDTH-1:0] link_data_nxt;

    logic [WIDTH-1:0] alu_pc, alu_imm, alu_out, alu_link;
    logic             alu_jump, alu_jal;

    // Single ALU shared between sequential increment and redirect targets.
    always_comb begin
        alu_pc   = pc;
        alu_imm  = '0;
        alu_jump = 1'b0;
        alu_jal  = 1'b0;
        if (redir_valid) begin
            alu_pc   = redir_pc;
            alu_imm  = jump_imm;
            alu_jump = jump_en & ~jal_en;
            alu_jal  = jal_en;
        end
    end

    pcALU #(.WIDTH(WIDTH)) u_pcalu (
        .pc        (alu_pc),
        .immediate (alu_imm),
        .jumpEN    (alu_jump),
        .RTarget   (jal_target),
        .jalEN     (alu_jal),
        .pcOut     (alu_out),
        .Rlink     (alu_link)
    );

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        pend_pc_nxt     = pend_pc;
        flush_nxt       = flush;
        instr_nxt       = instr;
        instr_pc_nxt    = instr_pc;
        instr_valid_nxt = instr_valid;
        link_we_nxt     = redir_valid & jal_en;
        link_data_nxt   = (redir_valid & jal_en) ? alu_link : link_data;

        unique case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (redir_valid) pc_nxt = alu_out;
            end
            FETCH: begin
                if (redir_valid) begin
                    if (imem_ack) begin
                        // Outstanding read completes now; newest target wins.
                        pc_nxt    = alu_out;
                        flush_nxt = 1'b0;
                    end else begin
                        pend_pc_nxt = alu_out;
                        flush_nxt   = 1'b1;
                    end
                end else if (imem_ack) begin
                    if (flush) begin
                        pc_nxt    = pend_pc;
                        flush_nxt = 1'b0;
                    end else begin
                        instr_nxt       = imem_rdata;
                        instr_pc_nxt    = pc;
                        instr_valid_nxt = 1'b1;
                        state_nxt       = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redir_valid || instr_ready) begin
                    pc_nxt          = alu_out;
                    instr_valid_nxt = 1'b0;
                    state_nxt       = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_VEC;
            pend_pc     <= '0;
            flush       <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            link_we     <= 1'b0;
            link_data   <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pend_pc     <= pend_pc_nxt;
            flush       <= flush_nxt;
            instr       <= instr_nxt;
            instr_pc    <= instr_pc_nxt;
            instr_valid <= instr_valid_nxt;
            link_we     <= link_we_nxt;
            link_data   <= link_data_nxt;
        end
    end
endmodule

// File: tb/tb_fetch_seq.sv
// Directed table-driven bench for fetch_seq plus reset-pulse sequences.
module tb_fetch_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redir_valid = 1'b0;
    logic [15:0] redir_pc = '0;
    logic        jump_en = 1'b0;
    logic [15:0] jump_imm = '0;
    logic        jal_en = 1'b0;
    logic [15:0] jal_target = '0;
    logic        link_we;
    logic [15:0] link_data;

    int checks = 0;
    int failures = 0;

    fetch_seq #(.WIDTH(16), .RESET_VEC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .jump_en(jump_en), .jump_imm(jump_imm),
        .jal_en(jal_en), .jal_target(jal_target),
        .link_we(link_we), .link_data(link_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [15:0] rdata;
        logic        ready;
        logic        rv;
        logic [15:0] rpc;
        logic        je;
        logic [15:0] imm;
        logic        jal;
        logic [15:0] jt;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_vld;
        logic [15:0] e_ins;
        logic [15:0] e_ipc;
        logic        e_lwe;
        logic [15:0] e_ld;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic ack, logic [15:0] rdata, logic ready,
                                logic rv, logic [15:0] rpc, logic je, logic [15:0] imm,
                                logic jal, logic [15:0] jt,
                                logic e_req, logic [15:0] e_addr, logic e_vld,
                                logic [15:0] e_ins, logic [15:0] e_ipc,
                                logic e_lwe, logic [15:0] e_ld);
        vec_t v;
        v = '{ack, rdata, ready, rv, rpc, je, imm, jal, jt,
              e_req, e_addr, e_vld, e_ins, e_ipc, e_lwe, e_ld};
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic req, input logic [15:0] addr,
                           input logic vld, input logic [15:0] ins, input logic [15:0] ipc,
                           input logic lwe, input logic [15:0] ld);
        chk({tag, ".req"},   {15'd0, imem_req},    {15'd0, req});
        chk({tag, ".addr"},  imem_addr,            addr);
        chk({tag, ".valid"}, {15'd0, instr_valid}, {15'd0, vld});
        chk({tag, ".instr"}, instr,                ins);
        chk({tag, ".ipc"},   instr_pc,             ipc);
        chk({tag, ".lwe"},   {15'd0, link_we},     {15'd0, lwe});
        chk({tag, ".ldata"}, link_data,            ld);
    endtask

    task automatic clear_inputs();
        imem_ack = 0; imem_rdata = '0; instr_ready = 0;
        redir_valid = 0; redir_pc = '0; jump_en = 0; jump_imm = '0;
        jal_en = 0; jal_target = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ack rdata rdy | rv rpc je imm jal jt | req addr vld instr ipc lwe ldata
        add(1,16'h0000,1, 0,0,0,0,0,0,          1,16'h0000,0,16'h0000,16'h0000,0,16'h0000);
        add(1,16'hA000,1, 0,0,0,0,0,0,          0,16'h0000,1,16'hA000,16'h0000,0,16'h0000);
        add(1,16'h0000,1, 0,0,0,0,0,0,          1,16'h0001,0,16'hA000,16'h0000,0,16'h0000);
        add(1,16'hA001,1, 0,0,0,0,0,0,          0,16'h0001,1,16'hA001,16'h0001,0,16'h0000);
        add(1,16'h0000,1, 0,0,0,0,0,0,          1,16'h0002,0,16'hA001,16'h0001,0,16'h0000);
        add(1,16'hA002,1, 0,0,0,0,0,0,          0,16'h0002,1,16'hA002,16'h0002,0,16'h0000);
        // decode stalls five cycles in HOLD; ack is ignored there
        for (int i = 0; i < 5; i++)
            add(1,16'hBAD0,0, 0,0,0,0,0,0,      0,16'h0002,1,16'hA002,16'h0002,0,16'h0000);
        add(1,16'h0000,1, 0,0,0,0,0,0,          1,16'h0003,0,16'hA002,16'h0002,0,16'h0000);
        add(1,16'hA003,1, 0,0,0,0,0,0,          0,16'h0003,1,16'hA003,16'h0003,0,16'h0000);
        // jump in HOLD with ready also high: buffer dropped, target 1+9
        add(0,16'h0000,1, 1,16'h0001,1,16'h0009,0,0, 1,16'h000A,0,16'hA003,16'h0003,0,16'h0000);
        add(1,16'hA00A,0, 0,0,0,0,0,0,          0,16'h000A,1,16'hA00A,16'h000A,0,16'h0000);
        // JAL with jump_en also set: JAL wins, link = a+1
        add(0,16'h0000,0, 1,16'h000A,1,16'h0005,1,16'h1000, 1,16'h1000,0,16'hA00A,16'h000A,1,16'h000B);
        add(0,16'h0000,0, 0,0,0,0,0,0,          1,16'h1000,0,16'hA00A,16'h000A,0,16'h000B);
        add(1,16'hA100,0, 0,0,0,0,0,0,          0,16'h1000,1,16'hA100,16'h1000,0,16'h000B);
        add(0,16'h0000,1, 0,0,0,0,0,0,          1,16'h1001,0,16'hA100,16'h1000,0,16'h000B);
        // replay redirect during FETCH, ack three cycles later is discarded
        add(0,16'h0000,0, 1,16'h003F,0,0,0,0,   1,16'h1001,0,16'hA100,16'h1000,0,16'h000B);
        add(0,16'h0000,0, 0,0,0,0,0,0,          1,16'h1001,0,16'hA100,16'h1000,0,16'h000B);
        add(0,16'h0000,0, 0,0,0,0,0,0,          1,16'h1001,0,16'hA100,16'h1000,0,16'h000B);
        add(1,16'hBEEF,1, 0,0,0,0,0,0,          1,16'h0040,0,16'hA100,16'h1000,0,16'h000B);
        add(1,16'hA040,0, 0,0,0,0,0,0,          0,16'h0040,1,16'hA040,16'h0040,0,16'h000B);
        add(0,16'h0000,1, 0,0,0,0,0,0,          1,16'h0041,0,16'hA040,16'h0040,0,16'h000B);
        // two redirects while flushing: second (70 + -1) overwrites first
        add(0,16'h0000,0, 1,16'h0050,1,16'h0010,0,0, 1,16'h0041,0,16'hA040,16'h0040,0,16'h000B);
        add(0,16'h0000,0, 1,16'h0070,1,16'hFFFF,0,0, 1,16'h0041,0,16'hA040,16'h0040,0,16'h000B);
        add(1,16'hDEAD,0, 0,0,0,0,0,0,          1,16'h006F,0,16'hA040,16'h0040,0,16'h000B);
        // JAL arriving with the ack: data discarded, target FFFF
        add(1,16'hDEAD,0, 1,16'h006F,0,0,1,16'hFFFF, 1,16'hFFFF,0,16'hA040,16'h0040,1,16'h0070);
        add(1,16'hA0FF,0, 0,0,0,0,0,0,          0,16'hFFFF,1,16'hA0FF,16'hFFFF,0,16'h0070);
        // increment wraps to 0000
        add(0,16'h0000,1, 0,0,0,0,0,0,          1,16'h0000,0,16'hA0FF,16'hFFFF,0,16'h0070);
        add(1,16'h1234,0, 0,0,0,0,0,0,          0,16'h0000,1,16'h1234,16'h0000,0,16'h0070);
        add(0,16'h0000,1, 0,0,0,0,0,0,          1,16'h0001,0,16'h1234,16'h0000,0,16'h0070);

        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk_all("idle", 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000);

        for (int i = 0; i < vecs.size(); i++) begin
            imem_ack    = vecs[i].ack;
            imem_rdata  = vecs[i].rdata;
            instr_ready = vecs[i].ready;
            redir_valid = vecs[i].rv;
            redir_pc    = vecs[i].rpc;
            jump_en     = vecs[i].je;
            jump_imm    = vecs[i].imm;
            jal_en      = vecs[i].jal;
            jal_target  = vecs[i].jt;
            step();
            chk_all($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld,
                    vecs[i].e_ins, vecs[i].e_ipc, vecs[i].e_lwe, vecs[i].e_ld);
        end

        // asynchronous reset during a pending read at 0001
        clear_inputs();
        step();
        chk_all("pend", 1, 16'h0001, 0, 16'h1234, 16'h0000, 0, 16'h0070);
        #2;
        rst_n = 0;
        #1;
        chk_all("async_rst", 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        imem_ack = 1;
        imem_rdata = 16'hCAFE;
        step();
        chk_all("rst_hold", 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        @(negedge clk);
        rst_n = 1;
        imem_ack = 0;
        step();
        chk_all("restart", 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        imem_ack = 1;
        imem_rdata = 16'h5555;
        step();
        chk_all("restart_cap", 0, 16'h0000, 1, 16'h5555, 16'h0000, 0, 16'h0000);

        // redirect taken straight out of IDLE
        clear_inputs();
        @(negedge clk);
        rst_n = 0;
        #2;
        rst_n = 1;
        redir_valid = 1; jump_en = 1; redir_pc = 16'h0020; jump_imm = 16'h0003;
        step();
        chk_all("idle_redir", 1, 16'h0023, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        clear_inputs();
        step();
        chk_all("idle_redir2", 1, 16'h0023, 0, 16'h0000, 16'h0000, 0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
